// File: rtl/parking_gate_ctrl.sv
// parking_gate_ctrl
//   Single-lane parking gate controller. A vehicle at the entry sensor is
//   asked for a PIN. A correct PIN opens the gate. The vehicle is counted
//   into the lot when it clears the exit sensor with nobody behind it.
//   Repeated wrong PINs raise the PIN alarm. A second vehicle tailgating
//   through the open gate raises the blocking alarm. Either alarm is
//   cleared only by a correct PIN.
//
//   Optional feature: define PARKING_PIN_TIMEOUT_EN to abandon a PIN
//   entry after TIMEOUT idle cycles in WAIT_PIN. Without the macro,
//   WAIT_PIN waits until a PIN arrives or the vehicle backs away.
//
// Ports
//   clock     in   rising-edge clock
//   reset     in   asynchronous active-low reset
//   senr_e    in   vehicle present at the entry sensor
//   senr_x    in   vehicle present at the gate-exit sensor
//   pin       in   PIN value (PIN_W bits), valid with pin_vld
//   pin_vld   in   single-cycle PIN-entry strobe
//   car_out   in   single-cycle strobe, a vehicle left the lot
//   gate_o    out  gate open command
//   gate_cls  out  gate closed indication (!gate_o)
//   alm_pin   out  wrong-PIN alarm
//   alm_blkg  out  blocking / tailgate alarm
//   occ       out  current occupancy
//   full      out  occ == CAPACITY
module parking_gate_ctrl #(
    parameter int                PIN_W     = 8,
    parameter logic [PIN_W-1:0]  PIN_VAL   = PIN_W'(71),
    parameter int                MAX_TRIES = 3,
    parameter int                CAPACITY  = 16,
    parameter int                TIMEOUT   = 32
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic                          senr_e,
    input  logic                          senr_x,
    input  logic [PIN_W-1:0]              pin,
    input  logic                          pin_vld,
    input  logic                          car_out,
    output logic                          gate_o,
    output logic                          gate_cls,
    output logic                          alm_pin,
    output logic                          alm_blkg,
    output logic [$clog2(CAPACITY+1)-1:0] occ,
    output logic                          full
);

    localparam int OCC_W = $clog2(CAPACITY + 1);
    localparam int TRY_W = $clog2(MAX_TRIES + 1);
    localparam logic [OCC_W-1:0] OCC_CAP  = OCC_W'(CAPACITY);
    localparam logic [TRY_W-1:0] TRY_MAX  = TRY_W'(MAX_TRIES);
    localparam logic [TRY_W-1:0] TRY_LAST = TRY_W'(MAX_TRIES - 1);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        WAIT_PIN = 3'd1,
        OPEN     = 3'd2,
        PIN_ALM  = 3'd3,
        BLK_ALM  = 3'd4
    } state_t;

    state_t            state_p0, state_nxt;
    logic [TRY_W-1:0]  tries_p0;
    logic [OCC_W-1:0]  occ_p0;
    logic              pin_ok, pin_bad, lot_full;
    logic              tries_clr, tries_inc, entry, tmo_hit;

    // Try counter holds at MAX_TRIES rather than wrapping.
    function automatic logic [TRY_W-1:0] sat_inc_try(input logic [TRY_W-1:0] cur);
        if (cur == TRY_MAX)
            return cur;
        return cur + TRY_W'(1);
    endfunction

    // Occupancy update, saturating at 0 and CAPACITY. A departure from an
    // empty lot is ignored; an entry and a departure together cancel.
    function automatic logic [OCC_W-1:0] occ_update(input logic [OCC_W-1:0] cur,
                                                    input logic             add,
                                                    input logic             sub);
        logic sub_ok;
        sub_ok = sub && (cur != '0);
        if (add && sub_ok)
            return cur;
        if (add)
            return (cur == OCC_CAP) ? cur : cur + OCC_W'(1);
        if (sub_ok)
            return cur - OCC_W'(1);
        return cur;
    endfunction

    assign pin_ok   = pin_vld && (pin == PIN_VAL);
    assign pin_bad  = pin_vld && (pin != PIN_VAL);
    assign lot_full = (occ_p0 == OCC_CAP);

`ifdef PARKING_PIN_TIMEOUT_EN
    localparam int TMO_W = $clog2(TIMEOUT);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT - 1);

    // Counts consecutive WAIT_PIN cycles without a PIN strobe.
    logic [TMO_W-1:0] tmo_p0;

    assign tmo_hit = (state_p0 == WAIT_PIN) && !pin_vld && (tmo_p0 == TMO_LAST);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset)
            tmo_p0 <= '0;
        else if (state_p0 != WAIT_PIN || pin_vld || tmo_hit)
            tmo_p0 <= '0;
        else
            tmo_p0 <= tmo_p0 + TMO_W'(1);
    end
`else
    assign tmo_hit = 1'b0;
`endif

    // State and counter registers
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_p0 <= IDLE;
            tries_p0 <= '0;
            occ_p0   <= '0;
        end else begin
            state_p0 <= state_nxt;
            if (tries_clr)
                tries_p0 <= '0;
            else if (tries_inc)
                tries_p0 <= sat_inc_try(tries_p0);
            occ_p0 <= occ_update(occ_p0, entry, car_out);
        end
    end

    // Next-state and counter control
    always_comb begin
        state_nxt = state_p0;
        tries_clr = 1'b0;
        tries_inc = 1'b0;
        entry     = 1'b0;
        case (state_p0)
            IDLE: begin
                if (senr_e && !lot_full) begin
                    state_nxt = WAIT_PIN;
                    tries_clr = 1'b1;
                end
            end
            WAIT_PIN: begin
                if (pin_ok) begin
                    state_nxt = OPEN;
                end else if (pin_bad) begin
                    tries_inc = 1'b1;
                    if (tries_p0 == TRY_LAST)
                        state_nxt = PIN_ALM;
                end else if (!senr_e) begin
                    state_nxt = IDLE;
                end else if (tmo_hit) begin
                    state_nxt = IDLE;
                    tries_clr = 1'b1;
                end
            end
            OPEN: begin
                if (senr_x) begin
                    if (senr_e) begin
                        state_nxt = BLK_ALM;
                    end else begin
                        state_nxt = IDLE;
                        entry     = 1'b1;
                    end
                end
            end
            PIN_ALM, BLK_ALM: begin
                if (pin_ok) begin
                    state_nxt = OPEN;
                    tries_clr = 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Moore output decode
    always_comb begin
        gate_o   = (state_p0 == OPEN);
        gate_cls = (state_p0 != OPEN);
        alm_pin  = (state_p0 == PIN_ALM);
        alm_blkg = (state_p0 == BLK_ALM);
        occ      = occ_p0;
        full     = lot_full;
    end

endmodule
